// File: rtl/sp_ram_req_ctrl.sv
// sp_ram_req_ctrl
//   Request/response front-end for a single-port RAM with a registered
//   1-cycle read. Turns a valid/ready request stream (reads and byte-masked
//   writes) into RAM pin activity. Read data passes through a 2-entry
//   response FIFO, so downstream backpressure never drops data.
//
// Ports
//   CLK, RST_N        clock, synchronous active-low reset
//   REQ_*             request channel (valid/ready, we, addr, wdata, be)
//   RSP_*             read response channel (valid/ready, rdata)
//   RAM_A/DI/BW/CE/RDWEN  outputs to the RAM; RAM_DO  input from the RAM
//   STAT_RD_CNT/STAT_WR_CNT/STAT_STALL_CNT
//                     saturating activity counters. They are present only
//                     when SP_RAM_CTRL_STATS_EN is defined.
module sp_ram_req_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int COL_WIDTH  = 8,
  localparam int NUM_COL   = DATA_WIDTH / COL_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WE,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ_WDATA,
  input  logic [NUM_COL-1:0]    REQ_BE,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DATA_WIDTH-1:0] RSP_RDATA,
  output logic [ADDR_WIDTH-1:0] RAM_A,
  output logic [DATA_WIDTH-1:0] RAM_DI,
  output logic [NUM_COL-1:0]    RAM_BW,
  output logic                  RAM_CE,
  output logic                  RAM_RDWEN,
  input  logic [DATA_WIDTH-1:0] RAM_DO
`ifdef SP_RAM_CTRL_STATS_EN
  ,
  output logic [31:0]           STAT_RD_CNT,
  output logic [31:0]           STAT_WR_CNT,
  output logic [31:0]           STAT_STALL_CNT
`endif
);

  if (DATA_WIDTH % COL_WIDTH != 0) begin : g_bad_col
    $fatal(1, "sp_ram_req_ctrl: DATA_WIDTH must be a multiple of COL_WIDTH");
  end

  logic [1:0]            count;        // FIFO occupancy, 0..2
  logic                  rd_inflight;  // read issued last cycle; RAM_DO valid now
  logic                  head, tail;
  logic [DATA_WIDTH-1:0] fifo_q [2];

  logic acc, rd_acc, pop, push;
  logic [2:0] committed;

  // A read needs a FIFO slot for when its data lands. Slots in use are the
  // stored entries plus the in-flight read, minus any entry leaving this cycle.
  assign pop       = RSP_VALID & RSP_READY;
  assign push      = rd_inflight;
  assign committed = {1'b0, count} + {2'b0, rd_inflight} - {2'b0, pop};
  assign REQ_READY = RST_N & (REQ_WE | (committed < 3'd2));
  assign acc       = REQ_VALID & REQ_READY;
  assign rd_acc    = acc & ~REQ_WE;

  assign RAM_CE    = acc;
  assign RAM_RDWEN = REQ_WE;
  assign RAM_A     = REQ_ADDR;
  assign RAM_DI    = REQ_WDATA;
  assign RAM_BW    = REQ_WE ? REQ_BE : '0;

  assign RSP_VALID = (count != 2'd0);
  assign RSP_RDATA = fifo_q[head];

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      count       <= 2'd0;
      rd_inflight <= 1'b0;
      head        <= 1'b0;
      tail        <= 1'b0;
    end else begin
      rd_inflight <= rd_acc;
      if (push) tail <= ~tail;
      if (pop)  head <= ~head;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Data storage needs no reset; occupancy alone decides validity.
  always_ff @(posedge CLK) begin
    if (RST_N && push) fifo_q[tail] <= RAM_DO;
  end

`ifdef SP_RAM_CTRL_STATS_EN
  logic [31:0] stat_rd_q, stat_wr_q, stat_stall_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      stat_rd_q    <= '0;
      stat_wr_q    <= '0;
      stat_stall_q <= '0;
    end else begin
      if (rd_acc && stat_rd_q != '1)                    stat_rd_q    <= stat_rd_q + 32'd1;
      if (acc && REQ_WE && stat_wr_q != '1)             stat_wr_q    <= stat_wr_q + 32'd1;
      if (REQ_VALID && !REQ_READY && stat_stall_q != '1) stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign STAT_RD_CNT    = stat_rd_q;
  assign STAT_WR_CNT    = stat_wr_q;
  assign STAT_STALL_CNT = stat_stall_q;
`endif

endmodule
